// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between buffered ALU results and memory loads.
// Loads normally win; a bounded starvation counter force-grants the ALU FIFO head.
module wb_port_arbiter #(
  parameter int DATA_W       = 64,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [4:0]                    alu_rd,
  input  logic [DATA_W-1:0]             alu_data,
  input  logic                          mem_valid,
  output logic                          mem_ready,
  input  logic [4:0]                    mem_rd,
  input  logic [DATA_W-1:0]             mem_data,
  output logic                          rf_we,
  output logic [4:0]                    rf_waddr,
  output logic [DATA_W-1:0]             rf_wdata,
  output logic [$clog2(FIFO_DEPTH):0]   alu_pending
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [4:0]        rd_mem   [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem [FIFO_DEPTH];

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  logic              fifo_empty;
  logic              force_grant;
  logic              alu_acc;
  logic              pop;
  logic              push;
  logic              mem_win;
  logic              bypass;
  logic [4:0]        head_rd;
  logic [DATA_W-1:0] head_data;

  assign fifo_empty  = (count_q == '0);
  assign force_grant = (starve_q == STARVE_MAX) && !fifo_empty;

  // Ready depends only on state, so a full FIFO stays closed even on a pop cycle.
  assign alu_ready   = (count_q != FULL_CNT);
  assign mem_ready   = !force_grant;
  assign alu_acc     = alu_valid && alu_ready;

  assign head_rd     = rd_mem[rd_ptr_q];
  assign head_data   = data_mem[rd_ptr_q];

  // Exactly one winner per cycle; x0 loads fall through so the FIFO can drain.
  always_comb begin
    pop     = 1'b0;
    mem_win = 1'b0;
    bypass  = 1'b0;
    if (force_grant) begin
      pop = 1'b1;
    end else if (mem_valid && (mem_rd != 5'd0)) begin
      mem_win = 1'b1;
    end else if (!fifo_empty) begin
      pop = 1'b1;
    end else if (alu_acc && (alu_rd != 5'd0)) begin
      bypass = 1'b1;
    end
  end

  assign push = alu_acc && (alu_rd != 5'd0) && !bypass;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (mem_win && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Address/data hold their last value on idle cycles; only rf_we drops.
  always_comb begin
    rf_we_d    = pop || mem_win || bypass;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (pop) begin
      rf_waddr_d = head_rd;
      rf_wdata_d = head_data;
    end else if (mem_win) begin
      rf_waddr_d = mem_rd;
      rf_wdata_d = mem_data;
    end else if (bypass) begin
      rf_waddr_d = alu_rd;
      rf_wdata_d = alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      rd_mem[wr_ptr_q]   <= alu_rd;
      data_mem[wr_ptr_q] <= alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign alu_pending = count_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus randomized traffic,
// checked against a queue-based reference model of the arbitration rules.
module tb_wb_port_arbiter;

  localparam int DATA_W       = 64;
  localparam int FIFO_DEPTH   = 2;
  localparam int STARVE_LIMIT = 4;
  localparam int CW           = $clog2(FIFO_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              alu_valid;
  logic              alu_ready;
  logic [4:0]        alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [4:0]        mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [CW-1:0]     alu_pending;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .alu_pending(alu_pending)
  );

  typedef struct {
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t              fifo_m[$];
  int                starve_m;
  logic              exp_we;
  logic [4:0]        exp_waddr;
  logic [DATA_W-1:0] exp_wdata;
  int                checks = 0;
  int                errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check ready/occupancy, advance model, check write-back.
  task automatic step(input logic r, input logic av, input logic [4:0] ard,
                      input logic [DATA_W-1:0] ad, input logic mv,
                      input logic [4:0] mrd, input logic [DATA_W-1:0] md);
    int   sz;
    bit   force_m, a_acc, pop, mem_win, byp;
    ent_t e;
    rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    #1;
    sz      = fifo_m.size();
    force_m = (starve_m == STARVE_LIMIT) && (sz > 0);
    check_eq("alu_ready", 64'(alu_ready), 64'(sz < FIFO_DEPTH));
    check_eq("mem_ready", 64'(mem_ready), 64'(!force_m));
    check_eq("alu_pending", 64'(alu_pending), 64'(sz));
    if (r) begin
      fifo_m.delete();
      starve_m  = 0;
      exp_we    = 1'b0;
      exp_waddr = '0;
      exp_wdata = '0;
    end else begin
      a_acc = av && (sz < FIFO_DEPTH);
      pop = 0; mem_win = 0; byp = 0;
      if (force_m)                 pop = 1;
      else if (mv && mrd != 0)     mem_win = 1;
      else if (sz > 0)             pop = 1;
      else if (a_acc && ard != 0)  byp = 1;
      exp_we = pop || mem_win || byp;
      if (pop) begin
        e = fifo_m.pop_front();
        exp_waddr = e.rd; exp_wdata = e.data;
      end else if (mem_win) begin
        exp_waddr = mrd; exp_wdata = md;
      end else if (byp) begin
        exp_waddr = ard; exp_wdata = ad;
      end
      if (sz == 0 || pop)                          starve_m = 0;
      else if (mem_win && starve_m < STARVE_LIMIT) starve_m++;
      if (a_acc && ard != 0 && !byp) begin
        e.rd = ard; e.data = ad;
        fifo_m.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    check_eq("rf_we", 64'(rf_we), 64'(exp_we));
    if (exp_we || r) begin
      check_eq("rf_waddr", 64'(rf_waddr), 64'(exp_waddr));
      check_eq("rf_wdata", 64'(rf_wdata), 64'(exp_wdata));
    end
    if (rf_we) $display("wb t=%0t r%0d <= %0h", $time, rf_waddr, rf_wdata);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
  endtask

  function automatic logic [4:0] rand_rd();
    return ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
  endfunction

  initial begin
    logic [4:0]        q_rd [3];
    logic [DATA_W-1:0] q_dat[3];
    int                idx;
    int                pa, pm;

    rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    repeat (2) @(posedge clk);
    #1;
    fifo_m.delete(); starve_m = 0; exp_we = 0; exp_waddr = '0; exp_wdata = '0;
    check_eq("reset_rf_we", 64'(rf_we), 64'(0));
    check_eq("reset_rf_waddr", 64'(rf_waddr), 64'(0));
    check_eq("reset_rf_wdata", 64'(rf_wdata), 64'(0));
    check_eq("reset_pending", 64'(alu_pending), 64'(0));
    check_eq("reset_alu_ready", 64'(alu_ready), 64'(1));
    check_eq("reset_mem_ready", 64'(mem_ready), 64'(1));

    // ALU bypass into an empty FIFO
    step(1'b0, 1'b1, 5'd5, 64'hAA, 1'b0, 5'd0, '0);
    check_eq("bypass_waddr", 64'(rf_waddr), 64'(5));
    check_eq("bypass_pending", 64'(alu_pending), 64'(0));

    // Simultaneous load and ALU result: load first, ALU next cycle
    step(1'b0, 1'b1, 5'd4, 64'h22, 1'b1, 5'd3, 64'h11);
    check_eq("sim_first_waddr", 64'(rf_waddr), 64'(3));
    idle();
    check_eq("sim_second_waddr", 64'(rf_waddr), 64'(4));

    // Starvation: r7 queued, loads held every cycle
    step(1'b0, 1'b1, 5'd7, 64'h77, 1'b1, 5'd2, 64'h55);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd6, 64'h66 + 64'(i));
    idle();

    // Three back-to-back ALU results under constant load pressure
    q_rd[0] = 5'd10; q_rd[1] = 5'd11; q_rd[2] = 5'd12;
    q_dat[0] = 64'hA0; q_dat[1] = 64'hA1; q_dat[2] = 64'hA2;
    idx = 0;
    for (int i = 0; i < 14; i++) begin
      if (idx < 3) begin
        logic acc;
        acc = alu_ready;
        step(1'b0, 1'b1, q_rd[idx], q_dat[idx], 1'b1, 5'd8, 64'h800 + 64'(i));
        if (acc) idx++;
      end else begin
        step(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd8, 64'h800 + 64'(i));
      end
    end
    check_eq("b2b_all_accepted", 64'(idx), 64'(3));
    repeat (3) idle();

    // x0 load does not block a FIFO pop; x0 ALU result is dropped
    step(1'b0, 1'b1, 5'd9, 64'h99, 1'b1, 5'd2, 64'h2);
    step(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd0, 64'hDEAD);
    check_eq("x0_pop_waddr", 64'(rf_waddr), 64'(9));
    step(1'b0, 1'b1, 5'd0, 64'hBEEF, 1'b0, 5'd0, '0);
    check_eq("x0_alu_no_we", 64'(rf_we), 64'(0));

    // Reset with a full FIFO discards queued entries
    step(1'b0, 1'b1, 5'd13, 64'h13, 1'b1, 5'd1, 64'h1);
    step(1'b0, 1'b1, 5'd14, 64'h14, 1'b1, 5'd1, 64'h2);
    step(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    step(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);

    // Randomized traffic with shifting valid densities
    pa = 50; pm = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        pa = $urandom_range(10, 100);
        pm = $urandom_range(10, 100);
      end
      step(($urandom_range(0, 149) == 0),
           ($urandom_range(1, 100) <= pa), rand_rd(), {$urandom, $urandom},
           ($urandom_range(1, 100) <= pm), rand_rd(), {$urandom, $urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two completion streams: ALU results and memory-load results.
- Sits between the execute/memory stages and the register file. It replaces the "mem_read ? mem : alu" select with a sequenced, registered arbiter.
- ALU results are buffered in a small FIFO. Memory returns have priority, with a starvation limit that guarantees ALU progress.

Parameters:
- DATA_W, 64, width of the write-back data.
- FIFO_DEPTH, 2, ALU result buffer entries; power of two, minimum 2.
- STARVE_LIMIT, 4, consecutive cycles a non-empty ALU FIFO may lose arbitration before it is force-granted; minimum 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- alu_valid  input  1  ALU result offered.
- alu_ready  output  1  ALU result accepted this cycle when alu_valid is also high.
- alu_rd  input  5  ALU destination register.
- alu_data  input  DATA_W  ALU result.
- mem_valid  input  1  load data offered.
- mem_ready  output  1  load data accepted this cycle when mem_valid is also high.
- mem_rd  input  5  load destination register.
- mem_data  input  DATA_W  load data.
- rf_we  output  1  register-file write enable (registered).
- rf_waddr  output  5  write address (registered).
- rf_wdata  output  DATA_W  write data (registered).
- alu_pending  output  $clog2(FIFO_DEPTH)+1  current ALU FIFO occupancy.

Behaviour:
- Reset (rst=1 at posedge): FIFO empty, pointers 0, starve_cnt=0, rf_we=0, rf_waddr=0, rf_wdata=0, alu_pending=0. Any in-flight entries are discarded.
- alu_ready = (alu_pending < FIFO_DEPTH). It is combinational from state only and never depends on alu_valid.
- mem_ready = !(force), where force = (starve_cnt == STARVE_LIMIT) && FIFO non-empty.
- Both handshakes complete on valid && ready at the posedge.
- Grant order each cycle, with exactly one write selected:
  1. force → pop the FIFO head.
  2. Otherwise mem_valid with mem_rd != 0 → write the load.
  3. Otherwise FIFO non-empty → pop the head.
  4. Otherwise an accepted ALU result with alu_rd != 0 bypasses the FIFO directly to the output register.
- Accepted ALU results that are not bypassed and have alu_rd != 0 are pushed to the FIFO tail. Push and pop may occur in the same cycle; occupancy is then unchanged.
- A full FIFO deasserts alu_ready even if a pop occurs that cycle. There is no same-cycle refill.
- x0 destination: accepted on either port, never written, never pushed. A mem x0 handshake does not block a FIFO pop in the same cycle.
- Output latency: rf_we/rf_waddr/rf_wdata are updated at the posedge after the winning handshake, i.e. 1 cycle. rf_we=0 in any cycle with no winner.
- starve_cnt:
  - Increments when the FIFO is non-empty and a memory write wins.
  - Clears to 0 on any FIFO pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Ordering: ALU results retire in acceptance order. Ordering between the two streams to the same rd is the issuer's responsibility; this block does not reorder or merge them.
- Pointers wrap modulo FIFO_DEPTH.
- Reset asserted mid-stream: takes effect at the next posedge. Outputs are zero the following cycle and no partially accepted data is written.

Test Plan:
- Reset, then alu_valid=1, alu_rd=5, alu_data=0xAA, FIFO empty, mem idle → alu_ready=1; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xAA; alu_pending stays 0.
- Same cycle: mem_valid rd=3 data=0x11 and ALU rd=4 data=0x22 → cycle+1 writes r3=0x11, cycle+2 writes r4=0x22; alu_pending goes 1 then 0.
- mem_valid held every cycle with FIFO holding rd=7 and STARVE_LIMIT=4 → 4 memory writes, then mem_ready=0 for one cycle and r7 is written; the held mem beat is written on the next cycle.
- Three ALU results back-to-back while mem_valid is held continuously → after 2 accepts, alu_ready=0 and alu_pending=2; the third is accepted only after a pop; FIFO order is preserved.
- mem_rd=0 with FIFO head rd=9 → mem_ready=1, no x0 write, r9 popped the same cycle; alu_rd=0 accepted → no write and no push.
- rst pulsed while alu_pending=2 → next cycle alu_pending=0, rf_we=0, alu_ready=1; the queued entries are never written.
